// File: rtl/b06_pkg.sv
// Shared definitions for the b06 eql/cont_eql generator and its event FIFO.
//   cc_sel_e  : cc_mux reference-select encodings
//   uscite_t  : 2-bit event code from the interrupt-handler FSM
//   CNT_W_DEF / TERM_DEF : default counter width and terminal count
package b06_pkg;

   typedef enum logic [1:0] {
      CC_NONE = 2'b00,
      CC_REFA = 2'b01,
      CC_REFB = 2'b10,
      CC_TERM = 2'b11
   } cc_sel_e;

   typedef logic [1:0] uscite_t;

   localparam int CNT_W_DEF = 4;
   localparam int TERM_DEF  = 15;

endpackage

// File: rtl/b06_eql_gen_if.sv
// Event-consumer handshake between the generator and whatever drains captured
// uscite codes.
//   ev_valid : FIFO head valid            (generator -> consumer)
//   ev_code  : FIFO head code, 0 if empty (generator -> consumer)
//   ev_ovf   : sticky overflow flag       (generator -> consumer)
//   ev_ready : consumer accepts the head  (consumer -> generator)
//   ovf_clr  : synchronous clear of ev_ovf (consumer -> generator)
interface b06_eql_gen_if;
   import b06_pkg::*;

   logic    ev_valid;
   uscite_t ev_code;
   logic    ev_ovf;
   logic    ev_ready;
   logic    ovf_clr;

   modport master (
      output ev_valid,
      output ev_code,
      output ev_ovf,
      input  ev_ready,
      input  ovf_clr
   );

   modport slave (
      input  ev_valid,
      input  ev_code,
      input  ev_ovf,
      output ev_ready,
      output ovf_clr
   );

endinterface

// File: rtl/b06_ev_fifo.sv
// Two-entry event FIFO with a sticky overflow flag.
//   clock, reset : rising-edge clock, async active-low reset
//   push, din    : write request and code
//   ready        : consumer ready; pop happens only when valid & ready
//   ovf_clr      : clears ovf unless an overflow occurs the same cycle
//   valid, dout  : head valid and head code (0 when empty)
//   ovf          : sticky overflow (push into a full FIFO with no pop)
module b06_ev_fifo
   import b06_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    push,
   input  uscite_t din,
   input  logic    ready,
   input  logic    ovf_clr,
   output logic    valid,
   output uscite_t dout,
   output logic    ovf
);

   uscite_t    mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       full;
   logic       pop;
   logic       do_push;
   logic       ovf_ev;

   assign full    = (count == 2'd2);
   assign valid   = (count != 2'd0);
   assign dout    = valid ? mem[rd_ptr] : '0;
   assign pop     = valid & ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign ovf_ev  = push & full & ~pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (ovf_ev) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/b06_eql_gen.sv
// Companion stage to the b06 interrupt-handler FSM. Produces the FSM's eql and
// cont_eql inputs from a saturating counter, and queues nonzero uscite codes
// for a downstream consumer.
//   clock, reset      : rising-edge clock, async active-low reset
//   enable_count      : counter runs while 1, clears to 0 when 0
//   cc_mux            : reference select (none / ref_a / ref_b / TERM)
//   uscite            : event code; each new nonzero code is queued once
//   ref_a, ref_b      : quasi-static compare references
//   eql               : registered compare hit
//   cont_eql          : registered terminal-count flag
//   ev_if (master)    : event FIFO head, overflow flag and consumer handshake
module b06_eql_gen
   import b06_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TERM  = TERM_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_count,
   input  logic [1:0]       cc_mux,
   input  uscite_t          uscite,
   input  logic [CNT_W-1:0] ref_a,
   input  logic [CNT_W-1:0] ref_b,
   output logic             eql,
   output logic             cont_eql,
   b06_eql_gen_if.master    ev_if
);

   localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] sel_ref;
   uscite_t          uscite_q;
   logic             push;

   always_comb begin
      sel_ref = '0;
      case (cc_mux)
         CC_REFA: sel_ref = ref_a;
         CC_REFB: sel_ref = ref_b;
         CC_TERM: sel_ref = TERM_V;
         default: sel_ref = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         eql      <= 1'b0;
         cont_eql <= 1'b0;
         uscite_q <= '0;
      end else begin
         if (!enable_count) begin
            cnt <= '0;
         end else if (cnt < TERM_V) begin
            cnt <= cnt + 1'b1;
         end
         // cc_mux=none masks the compare even though sel_ref is 0 and cnt may be 0.
         eql      <= enable_count & (cc_mux != CC_NONE) & (cnt == sel_ref);
         cont_eql <= enable_count & (cnt == TERM_V);
         uscite_q <= uscite;
      end
   end

   // Edge-detect on the code so a held code queues only once.
   assign push = (uscite != '0) && (uscite != uscite_q);

   b06_ev_fifo u_ev_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .din     (uscite),
      .ready   (ev_if.ev_ready),
      .ovf_clr (ev_if.ovf_clr),
      .valid   (ev_if.ev_valid),
      .dout    (ev_if.ev_code),
      .ovf     (ev_if.ev_ovf)
   );

endmodule
